// File: rtl/water_pkg.sv
// Shared types and helpers for the water-level input filter.
package water_pkg;

   localparam int MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      ACC_NONE    = 2'd0,
      ACC_VALID   = 2'd1,
      ACC_INVALID = 2'd2
   } accept_kind_e;

   // Counter width able to hold 0..max_value, never narrower than one bit.
   function automatic int cnt_width(input int max_value);
      int w;
      w = $clog2(max_value + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // True when the low 'width' bits read 0..01..1 from the LSB (all-zero and all-one included).
   function automatic logic is_thermometer(input logic [MAX_WIDTH-1:0] code, input int width);
      logic seen_zero;
      logic ok;
      seen_zero = 1'b0;
      ok        = 1'b1;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if (i < width) begin
            if (!code[i]) begin
               seen_zero = 1'b1;
            end else if (seen_zero) begin
               ok = 1'b0;
            end else begin
               ok = ok;
            end
         end else begin
            ok = ok;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous GPIO bits; only the second stage is exported.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // metastability chain
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= {WIDTH{1'b0}};
         sync_r <= {WIDTH{1'b0}};
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/water_level_filter.sv
// Debounces probe bits: accepts a level after DEPTH equal sample ticks, validates
// thermometer coding and raises a sticky fault when the input never settles.
module water_level_filter
   import water_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int DEPTH        = 4,
   parameter int SAMPLE_DIV   = 1,
   parameter int TIMEOUT      = 64,
   parameter int CHECK_THERMO = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] water_level_input,
   output logic [WIDTH-1:0] water_level,
   output logic             level_valid,
   output logic             level_changed,
   output logic             code_err,
   output logic             fault
);

   localparam int SW = cnt_width(DEPTH);
   localparam int TW = cnt_width(TIMEOUT);
   localparam int DW = cnt_width(SAMPLE_DIV - 1);

   typedef logic [SW-1:0] stable_cnt_t;
   typedef logic [TW-1:0] timeout_cnt_t;
   typedef logic [DW-1:0] div_cnt_t;

   localparam stable_cnt_t  DEPTH_C   = SW'(DEPTH);
   localparam stable_cnt_t  STABLE_1  = SW'(1);
   localparam timeout_cnt_t TO_MAX    = TW'(TIMEOUT);
   localparam timeout_cnt_t TO_1      = TW'(1);
   localparam div_cnt_t     DIV_LAST  = DW'(SAMPLE_DIV - 1);
   localparam div_cnt_t     DIV_1     = DW'(1);
   localparam logic         TO_ENABLE = (TIMEOUT != 0);
   localparam logic         THERMO_ON = (CHECK_THERMO != 0);

   logic [WIDTH-1:0] samp_s;
   logic [WIDTH-1:0] candidate_r;
   stable_cnt_t      stable_cnt_r;
   stable_cnt_t      stable_nxt_s;
   div_cnt_t         div_r;
   timeout_cnt_t     timeout_r;
   timeout_cnt_t     timeout_nxt_s;
   logic             tick_s;
   logic             changed_s;
   logic             code_ok_s;
   logic             count_s;
   logic             settled_r;
   accept_kind_e     accept_kind_s;

   logic [WIDTH-1:0] water_level_r;
   logic             level_valid_r;
   logic             level_changed_r;
   logic             code_err_r;
   logic             fault_r;

   sync_2ff #(
      .WIDTH (WIDTH)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (water_level_input),
      .q     (samp_s)
   );

   // sample tick, stability count and acceptance classification
   always_comb begin
      tick_s        = (div_r == DIV_LAST);
      changed_s     = (samp_s != candidate_r);
      stable_nxt_s  = stable_cnt_r;
      accept_kind_s = ACC_NONE;

      if (changed_s) begin
         stable_nxt_s = STABLE_1;
      end else if (stable_cnt_r == DEPTH_C) begin
         stable_nxt_s = DEPTH_C;
      end else begin
         stable_nxt_s = stable_cnt_r + STABLE_1;
      end

      if (THERMO_ON) begin
         code_ok_s = is_thermometer(MAX_WIDTH'(samp_s), WIDTH);
      end else begin
         code_ok_s = 1'b1;
      end

      // a candidate change always starts a fresh run, so DEPTH=1 still re-accepts
      if (tick_s && (stable_nxt_s == DEPTH_C) && ((stable_cnt_r != DEPTH_C) || changed_s)) begin
         accept_kind_s = code_ok_s ? ACC_VALID : ACC_INVALID;
      end else begin
         accept_kind_s = ACC_NONE;
      end
   end

   // timeout accounting: a settled, already accepted level does not age toward a fault
   always_comb begin
      count_s = TO_ENABLE && tick_s && (accept_kind_s != ACC_VALID) && !(settled_r && !changed_s);
      if (timeout_r == TO_MAX) begin
         timeout_nxt_s = TO_MAX;
      end else begin
         timeout_nxt_s = timeout_r + TO_1;
      end
   end

   // filter state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         candidate_r     <= {WIDTH{1'b0}};
         stable_cnt_r    <= {SW{1'b0}};
         div_r           <= {DW{1'b0}};
         timeout_r       <= {TW{1'b0}};
         settled_r       <= 1'b0;
         water_level_r   <= {WIDTH{1'b0}};
         level_valid_r   <= 1'b0;
         level_changed_r <= 1'b0;
         code_err_r      <= 1'b0;
         fault_r         <= 1'b0;
      end else begin
         level_changed_r <= 1'b0;
         code_err_r      <= 1'b0;
         div_r           <= tick_s ? {DW{1'b0}} : (div_r + DIV_1);

         if (tick_s) begin
            candidate_r  <= samp_s;
            stable_cnt_r <= stable_nxt_s;
            if (changed_s) begin
               settled_r <= 1'b0;
            end
         end

         if (count_s) begin
            timeout_r <= timeout_nxt_s;
            if (timeout_nxt_s == TO_MAX) begin
               fault_r <= 1'b1;
            end
         end

         case (accept_kind_s)
            ACC_VALID: begin
               if (!level_valid_r || (samp_s != water_level_r)) begin
                  water_level_r   <= samp_s;
                  level_changed_r <= 1'b1;
               end
               level_valid_r <= 1'b1;
               fault_r       <= 1'b0;
               timeout_r     <= {TW{1'b0}};
               settled_r     <= 1'b1;
            end
            ACC_INVALID: begin
               code_err_r <= 1'b1;
            end
            default: begin
               code_err_r <= 1'b0;
            end
         endcase
      end
   end

   assign water_level   = water_level_r;
   assign level_valid   = level_valid_r;
   assign level_changed = level_changed_r;
   assign code_err      = code_err_r;
   assign fault         = fault_r;

endmodule

// File: tb/tb_water_level_filter.sv
// Scoreboard bench for water_level_filter across three parameter sets.
module tb_water_level_filter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [3:0] in_a, in_b, in_c;
   logic [3:0] wl_a, wl_b, wl_c;
   logic       lv_a, lv_b, lv_c;
   logic       lc_a, lc_b, lc_c;
   logic       ce_a, ce_b, ce_c;
   logic       ft_a, ft_b, ft_c;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [3:0] qa[$];
   logic [3:0] qb[$];
   logic [3:0] qc[$];

   water_level_filter #(.WIDTH(4), .DEPTH(4), .SAMPLE_DIV(1), .TIMEOUT(8), .CHECK_THERMO(1)) u_a (
      .clk(clk), .reset(reset), .water_level_input(in_a), .water_level(wl_a),
      .level_valid(lv_a), .level_changed(lc_a), .code_err(ce_a), .fault(ft_a));

   water_level_filter #(.WIDTH(4), .DEPTH(4), .SAMPLE_DIV(1), .TIMEOUT(8), .CHECK_THERMO(0)) u_b (
      .clk(clk), .reset(reset), .water_level_input(in_b), .water_level(wl_b),
      .level_valid(lv_b), .level_changed(lc_b), .code_err(ce_b), .fault(ft_b));

   water_level_filter #(.WIDTH(4), .DEPTH(2), .SAMPLE_DIV(3), .TIMEOUT(64), .CHECK_THERMO(1)) u_c (
      .clk(clk), .reset(reset), .water_level_input(in_c), .water_level(wl_c),
      .level_valid(lv_c), .level_changed(lc_c), .code_err(ce_c), .fault(ft_c));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // edges since reset release, matching the sample divider phase
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // scoreboard: every level_changed pulse must match the oldest expected level
   always @(negedge clk) begin
      if (lc_a) begin
         if (qa.size() == 0) check_eq("lc_a_spurious", 32'(lc_a), 32'd0);
         else                check_eq("sb_a", 32'(wl_a), 32'(qa.pop_front()));
      end
      if (lc_b) begin
         if (qb.size() == 0) check_eq("lc_b_spurious", 32'(lc_b), 32'd0);
         else                check_eq("sb_b", 32'(wl_b), 32'(qb.pop_front()));
      end
      if (lc_c) begin
         if (qc.size() == 0) check_eq("lc_c_spurious", 32'(lc_c), 32'd0);
         else                check_eq("sb_c", 32'(wl_c), 32'(qc.pop_front()));
      end
   end

   initial begin
      int ce_cnt;
      reset = 1'b1;
      in_a  = 4'b0000;
      in_b  = 4'b0000;
      in_c  = 4'b0000;
      step(3);
      check_eq("rst_wl",    32'(wl_a), 32'd0);
      check_eq("rst_valid", 32'(lv_a), 32'd0);
      check_eq("rst_lc",    32'(lc_a), 32'd0);
      check_eq("rst_ce",    32'(ce_a), 32'd0);
      check_eq("rst_fault", 32'(ft_a), 32'd0);

      // 1: 0011 accepted on the sixth edge after it is applied
      reset = 1'b0;
      in_a  = 4'b0011;
      qa.push_back(4'b0011);
      qb.push_back(4'b0000);
      qc.push_back(4'b0000);
      step(5);
      check_eq("t1_wl_e5", 32'(wl_a), 32'd0);
      check_eq("t1_lc_e5", 32'(lc_a), 32'd0);
      check_eq("t1_lv_e5", 32'(lv_a), 32'd0);
      step(1);
      check_eq("t1_wl_e6", 32'(wl_a), 32'(4'b0011));
      check_eq("t1_lc_e6", 32'(lc_a), 32'd1);
      check_eq("t1_lv_e6", 32'(lv_a), 32'd1);
      step(1);
      check_eq("t1_lc_e7", 32'(lc_a), 32'd0);
      step(4);

      // 2: accept 0001, then a 3-cycle glitch must not disturb it
      in_a = 4'b0001;
      qa.push_back(4'b0001);
      step(6);
      check_eq("t2_wl", 32'(wl_a), 32'(4'b0001));
      step(3);
      in_a = 4'b0011;
      step(3);
      in_a = 4'b0001;
      for (int i = 0; i < 14; i++) begin
         step(1);
         check_eq("t2_glitch_hold", 32'(wl_a), 32'(4'b0001));
      end

      // 4: toggling every cycle faults after 8 ticks; a stable valid code clears it
      for (int k = 0; k < 12; k++) begin
         in_a = (k % 2 == 0) ? 4'b0000 : 4'b1111;
         step(1);
         if (k == 8) check_eq("t4_fault_e9",  32'(ft_a), 32'd0);
         if (k == 9) check_eq("t4_fault_e10", 32'(ft_a), 32'd1);
      end
      in_a = 4'b0111;
      qa.push_back(4'b0111);
      step(5);
      check_eq("t4_fault_held", 32'(ft_a), 32'd1);
      check_eq("t4_wl_held",    32'(wl_a), 32'(4'b0001));
      step(1);
      check_eq("t4_fault_clr",  32'(ft_a), 32'd0);
      check_eq("t4_wl_new",     32'(wl_a), 32'(4'b0111));
      step(3);

      // 3a: non-thermometer code rejected once
      in_a = 4'b0101;
      step(5);
      check_eq("t3_ce_e5", 32'(ce_a), 32'd0);
      step(1);
      check_eq("t3_ce_e6", 32'(ce_a), 32'd1);
      check_eq("t3_wl",    32'(wl_a), 32'(4'b0111));
      ce_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         ce_cnt += int'(ce_a);
      end
      check_eq("t3_ce_once", 32'(ce_cnt), 32'd0);
      check_eq("t3_lv",      32'(lv_a),   32'd1);

      // 3b: same code accepted with checking disabled
      in_b = 4'b0101;
      qb.push_back(4'b0101);
      step(5);
      check_eq("t3b_wl_e5", 32'(wl_b), 32'd0);
      step(1);
      check_eq("t3b_wl_e6", 32'(wl_b), 32'(4'b0101));
      check_eq("t3b_lc",    32'(lc_b), 32'd1);
      check_eq("t3b_ce",    32'(ce_b), 32'd0);

      // 5: divide-by-3, DEPTH=2; a glitch between ticks is invisible
      for (int i = 0; i < 3 && (cyc % 3) != 0; i++) step(1);
      check_eq("t5_phase", 32'(cyc % 3), 32'd0);
      in_c = 4'b1111;
      qc.push_back(4'b1111);
      step(1);
      in_c = 4'b0000;
      step(2);
      in_c = 4'b1111;
      step(2);
      check_eq("t5_wl_e5", 32'(wl_c), 32'd0);
      check_eq("t5_lc_e5", 32'(lc_c), 32'd0);
      step(1);
      check_eq("t5_wl_e6", 32'(wl_c), 32'(4'b1111));
      check_eq("t5_lc_e6", 32'(lc_c), 32'd1);
      step(2);

      // 6: reset lands on the acceptance edge
      in_a = 4'b0011;
      step(5);
      reset = 1'b1;
      step(1);
      check_eq("t6_wl",    32'(wl_a), 32'd0);
      check_eq("t6_lv",    32'(lv_a), 32'd0);
      check_eq("t6_lc",    32'(lc_a), 32'd0);
      check_eq("t6_ce",    32'(ce_a), 32'd0);
      check_eq("t6_fault", 32'(ft_a), 32'd0);
      reset = 1'b0;
      qa.push_back(4'b0011);
      qb.push_back(4'b0101);
      qc.push_back(4'b1111);
      step(5);
      check_eq("t6_lc_e5", 32'(lc_a), 32'd0);
      step(1);
      check_eq("t6_lc_e6", 32'(lc_a), 32'd1);
      check_eq("t6_wl_e6", 32'(wl_a), 32'(4'b0011));
      check_eq("t6_lv_e6", 32'(lv_a), 32'd1);
      step(20);
      check_eq("qa_drained", 32'(qa.size()), 32'd0);
      check_eq("qb_drained", 32'(qb.size()), 32'd0);
      check_eq("qc_drained", 32'(qc.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
